octant_mapper: RTL and testbench

Streaming, pipelined successor to the combinational octant flip in the Bresenham path. It takes points from a Bresenham core that runs in normalised octant-0 coordinates and applies the per-line flip/swap. It then translates each point by the line origin and flags points that fall outside the map. Each line is bound once through a config handshake, and points flow through with valid/ready at one point per cycle. The block sits between the Bresenham core and the map-RAM update logic.

---
 rtl/bresenham_pkg.sv | 23 ++
 rtl/ram_pkg.sv | 5 +
 rtl/octant_stage.sv | 27 ++
 rtl/octant_mapper.sv | 142 ++++++++++++++
 tb/tb_octant_mapper.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/bresenham_pkg.sv
// Shared types for the Bresenham line path: coordinate widths, line config, octant FSM states.
package bresenham_pkg;
  localparam int X_W   = 9;
  localparam int Y_W   = 8;
  localparam int D_W   = ((X_W > Y_W) ? X_W : Y_W) + 1;
  localparam int CNT_W = 16;

  typedef logic signed [D_W-1:0] offset_t;

  typedef struct packed {
    logic           flip_x;
    logic           flip_y;
    logic           swap;
    logic [X_W-1:0] origin_x;
    logic [Y_W-1:0] origin_y;
  } octant_cfg_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } octant_state_e;
endpackage

// File: rtl/ram_pkg.sv
// Map RAM geometry shared by everything that addresses the occupancy map.
package ram_pkg;
  localparam int MAP_COLS = 400;
  localparam int MAP_ROWS = 200;
endpackage

// File: rtl/octant_stage.sv
// Generic registered valid/ready pipeline stage carrying a payload of type T.
// Latency: 1 cycle. Full throughput.
// Backpressure: accepts whenever empty or downstream takes the current word; holds data while stalled.
module octant_stage #(
  parameter type T = logic
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);
  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end
endmodule

// File: rtl/octant_mapper.sv
// Maps normalised octant-0 Bresenham points to absolute map coordinates with out-of-bounds flag.
// Latency: 2 cycles from input handshake to out_valid, 1 point/cycle.
// Backpressure: out_ready stalls both stages; in_ready drops once both are full.
module octant_mapper
  import bresenham_pkg::*;
#(
  parameter int X_WIDTH    = bresenham_pkg::X_W,
  parameter int Y_WIDTH    = bresenham_pkg::Y_W,
  parameter int MAP_WIDTH  = ram_pkg::MAP_COLS,
  parameter int MAP_HEIGHT = ram_pkg::MAP_ROWS,
  parameter int CNT_WIDTH  = bresenham_pkg::CNT_W,
  localparam int D_WIDTH   = ((X_WIDTH > Y_WIDTH) ? X_WIDTH : Y_WIDTH) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic                      cfg_flip_x,
  input  logic                      cfg_flip_y,
  input  logic                      cfg_swap,
  input  logic [X_WIDTH-1:0]        cfg_origin_x,
  input  logic [Y_WIDTH-1:0]        cfg_origin_y,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [D_WIDTH-1:0] in_x,
  input  logic signed [D_WIDTH-1:0] in_y,
  input  logic                      in_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [X_WIDTH-1:0]        out_x,
  output logic [Y_WIDTH-1:0]        out_y,
  output logic                      out_oob,
  output logic                      out_last,
  output logic [CNT_WIDTH-1:0]      point_count
);
  localparam int AW = D_WIDTH + 1;
  localparam int SW = D_WIDTH + 2;
  localparam logic signed [SW-1:0] MAP_W_S = SW'(MAP_WIDTH);
  localparam logic signed [SW-1:0] MAP_H_S = SW'(MAP_HEIGHT);

  typedef struct packed {
    logic signed [AW-1:0] a;
    logic signed [AW-1:0] b;
    logic                 last;
  } s1_t;

  typedef struct packed {
    logic [X_WIDTH-1:0] x;
    logic [Y_WIDTH-1:0] y;
    logic               oob;
    logic               last;
  } s2_t;

  octant_state_e state, state_nxt;
  octant_cfg_t   cfg;
  s1_t           s1_in, s1_out;
  s2_t           s2_in, s2_out;
  logic          s1_adv, s2_adv, v1, s1_in_valid;
  logic          in_hs, out_hs, cfg_hs;
  logic signed [AW-1:0] ext_x, ext_y, fx, fy;
  logic signed [SW-1:0] org_x, org_y, sx, sy;

  assign cfg_hs = cfg_valid && cfg_ready;
  assign in_hs  = in_valid && in_ready;
  assign out_hs = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cfg_hs) state_nxt = STREAM;
      STREAM:  if (in_hs && in_last) state_nxt = DRAIN;
      DRAIN:   if (out_hs && out_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cfg_ready = (state == IDLE);
    in_ready  = (state == STREAM) && s1_adv;
  end

  // Config only moves in IDLE, when the pipeline is empty, so in-flight points never see a change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cfg <= '0;
    else if (cfg_hs) cfg <= '{flip_x: cfg_flip_x, flip_y: cfg_flip_y, swap: cfg_swap,
                              origin_x: cfg_origin_x, origin_y: cfg_origin_y};
  end

  // One extra bit so negating the most negative offset cannot wrap.
  assign ext_x = {in_x[D_WIDTH-1], in_x};
  assign ext_y = {in_y[D_WIDTH-1], in_y};
  assign fx    = cfg.flip_x ? -ext_x : ext_x;
  assign fy    = cfg.flip_y ? -ext_y : ext_y;

  always_comb begin
    s1_in.a    = cfg.swap ? fy : fx;
    s1_in.b    = cfg.swap ? fx : fy;
    s1_in.last = in_last;
  end

  assign s1_in_valid = in_valid && (state == STREAM);

  octant_stage #(.T(s1_t)) u_stage1 (
    .clk(clk), .rst(rst),
    .in_valid(s1_in_valid), .in_ready(s1_adv), .in_data(s1_in),
    .out_valid(v1), .out_ready(s2_adv), .out_data(s1_out)
  );

  assign org_x = SW'({1'b0, cfg.origin_x});
  assign org_y = SW'({1'b0, cfg.origin_y});
  assign sx    = org_x + {s1_out.a[AW-1], s1_out.a};
  assign sy    = org_y + {s1_out.b[AW-1], s1_out.b};

  always_comb begin
    s2_in.x    = sx[X_WIDTH-1:0];
    s2_in.y    = sy[Y_WIDTH-1:0];
    s2_in.oob  = sx[SW-1] || (sx >= MAP_W_S) || sy[SW-1] || (sy >= MAP_H_S);
    s2_in.last = s1_out.last;
  end

  octant_stage #(.T(s2_t)) u_stage2 (
    .clk(clk), .rst(rst),
    .in_valid(v1), .in_ready(s2_adv), .in_data(s2_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(s2_out)
  );

  assign out_x    = s2_out.x;
  assign out_y    = s2_out.y;
  assign out_oob  = s2_out.oob;
  assign out_last = s2_out.last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             point_count <= '0;
    else if (cfg_hs)                     point_count <= '0;
    else if (out_hs && point_count != '1) point_count <= point_count + CNT_WIDTH'(1);
  end
endmodule

// File: tb/tb_octant_mapper.sv
// Directed bench for octant_mapper: hand-computed mapped points, latency, backpressure, reset.
module tb_octant_mapper;
  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_valid, cfg_ready, cfg_flip_x, cfg_flip_y, cfg_swap;
  logic [8:0]        cfg_origin_x;
  logic [7:0]        cfg_origin_y;
  logic              in_valid, in_ready, in_last;
  logic signed [9:0] in_x, in_y;
  logic              out_valid, out_ready, out_oob, out_last;
  logic [8:0]        out_x;
  logic [7:0]        out_y;
  logic [15:0]       point_count;

  typedef struct packed {
    logic [8:0] x;
    logic [7:0] y;
    logic       oob;
    logic       last;
  } obs_t;

  obs_t out_q[$];
  int   out_cyc_q[$];
  int   in_cyc_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  octant_mapper dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_flip_x(cfg_flip_x), .cfg_flip_y(cfg_flip_y), .cfg_swap(cfg_swap),
    .cfg_origin_x(cfg_origin_x), .cfg_origin_y(cfg_origin_y),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_oob(out_oob), .out_last(out_last),
    .point_count(point_count)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Inputs change just after posedge, so the negedge view is what the next edge will see.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      out_q.push_back('{x: out_x, y: out_y, oob: out_oob, last: out_last});
      out_cyc_q.push_back(cyc);
    end
    if (!rst && in_valid && in_ready) in_cyc_q.push_back(cyc);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    out_q.delete();
    out_cyc_q.delete();
    in_cyc_q.delete();
  endtask

  task automatic apply_cfg(input logic fx, input logic fy, input logic sw,
                           input logic [8:0] ox, input logic [7:0] oy);
    logic ok;
    ok = 1'b0;
    clear_logs();
    cfg_flip_x = fx; cfg_flip_y = fy; cfg_swap = sw;
    cfg_origin_x = ox; cfg_origin_y = oy;
    cfg_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (cfg_ready) ok = 1'b1;
      step();
      if (ok) break;
    end
    cfg_valid = 1'b0;
    check_val("cfg_accept", ok, 1);
    check_val("cnt_cleared", point_count, 0);
  endtask

  task automatic send_point(input int x, input int y, input logic last);
    logic ok;
    ok = 1'b0;
    in_x = 10'(x); in_y = 10'(y); in_last = last;
    in_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      step();
      if (ok) break;
    end
    check_val("send_ok", ok, 1);
  endtask

  task automatic wait_last(input string tag);
    logic found;
    found = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (out_valid && out_ready && out_last) begin
        found = 1'b1;
        check_val({tag, "_cfgrdy_drain"}, cfg_ready, 0);
      end
      step();
      if (found) break;
    end
    check_val({tag, "_last_seen"}, found, 1);
    check_val({tag, "_cfgrdy_after"}, cfg_ready, 1);
  endtask

  task automatic check_out(input string tag, input int j, input int x, input int y,
                           input logic oob, input logic last);
    if (j < out_q.size()) begin
      check_val({tag, "_x"}, out_q[j].x, x);
      check_val({tag, "_y"}, out_q[j].y, y);
      check_val({tag, "_oob"}, out_q[j].oob, oob);
      check_val({tag, "_last"}, out_q[j].last, last);
    end else begin
      check_val({tag, "_present"}, out_q.size(), j + 1);
    end
  endtask

  initial begin
    logic acc;
    int   i;
    rst = 1'b1;
    cfg_valid = 0; cfg_flip_x = 0; cfg_flip_y = 0; cfg_swap = 0;
    cfg_origin_x = 0; cfg_origin_y = 0;
    in_valid = 0; in_x = 0; in_y = 0; in_last = 0;
    out_ready = 1'b1;
    step(); step();
    check_val("rst_cfg_ready", cfg_ready, 1);
    check_val("rst_in_ready", in_ready, 0);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_count", point_count, 0);
    check_val("rst_out_x", out_x, 0);
    check_val("rst_out_last", out_last, 0);
    rst = 1'b0;
    step();

    // Identity, origin (100,50)
    apply_cfg(0, 0, 0, 100, 50);
    send_point(0, 0, 0);
    send_point(3, 1, 0);
    send_point(5, 2, 1);
    in_valid = 0;
    wait_last("t1");
    check_out("t1_p0", 0, 100, 50, 0, 0);
    check_out("t1_p1", 1, 103, 51, 0, 0);
    check_out("t1_p2", 2, 105, 52, 0, 1);
    check_val("t1_nout", out_q.size(), 3);
    check_val("t1_nin", in_cyc_q.size(), 3);
    for (int j = 0; j < 3; j++)
      if (j < in_cyc_q.size() && j < out_cyc_q.size())
        check_val("t1_latency", out_cyc_q[j] - in_cyc_q[j], 2);
    check_val("t1_count", point_count, 3);

    // swap + flip_x: (4,1) -> (-4,1) -> (1,-4), plus origin (10,20)
    apply_cfg(1, 0, 1, 10, 20);
    send_point(4, 1, 1);
    in_valid = 0;
    wait_last("t2");
    check_out("t2_p0", 0, 11, 16, 0, 1);

    // flip_y pushes y negative: sy=-3 wraps to 253 in 8 bits
    apply_cfg(0, 1, 0, 0, 0);
    send_point(2, 3, 1);
    in_valid = 0;
    wait_last("t3a");
    check_out("t3a_p0", 0, 2, 253, 1, 1);

    // Right edge: 398+5 = 403 >= 400
    apply_cfg(0, 0, 0, 398, 0);
    send_point(5, 0, 1);
    in_valid = 0;
    wait_last("t3b");
    check_out("t3b_p0", 0, 403, 0, 1, 1);
    check_val("t3b_count", point_count, 1);

    // Backpressure: 5 stalled cycles fill exactly two stages
    apply_cfg(0, 0, 0, 0, 0);
    out_ready = 1'b0;
    i = 0;
    for (int c = 0; c < 5; c++) begin
      in_x = 10'(i); in_y = 0; in_last = (i == 3); in_valid = 1'b1;
      @(negedge clk);
      acc = in_ready;
      step();
      if (acc) i++;
    end
    check_val("t4_accepted", i, 2);
    check_val("t4_in_ready_stall", in_ready, 0);
    check_val("t4_out_valid_stall", out_valid, 1);
    check_val("t4_head_x", out_x, 0);
    out_ready = 1'b1;
    while (i < 4) begin
      send_point(i, 0, i == 3);
      i++;
    end
    in_valid = 0;
    wait_last("t4");
    check_val("t4_nout", out_q.size(), 4);
    for (int j = 0; j < 4; j++) check_out("t4_p", j, j, 0, 0, j == 3);
    for (int j = 1; j < 4; j++)
      if (j < out_cyc_q.size()) check_val("t4_b2b", out_cyc_q[j] - out_cyc_q[j-1], 1);
    check_val("t4_count", point_count, 4);

    // Config offered mid-line is ignored
    apply_cfg(0, 0, 0, 1, 2);
    send_point(0, 0, 0);
    in_valid = 0;
    cfg_origin_x = 7; cfg_origin_y = 7; cfg_valid = 1'b1;
    @(negedge clk);
    check_val("t5_cfgrdy_stream", cfg_ready, 0);
    step();
    cfg_valid = 1'b0;
    send_point(1, 1, 1);
    in_valid = 0;
    wait_last("t5");
    check_out("t5_p0", 0, 1, 2, 0, 0);
    check_out("t5_p1", 1, 2, 3, 0, 1);
    check_val("t5_count", point_count, 2);
    apply_cfg(0, 0, 0, 7, 7);
    send_point(0, 0, 1);
    in_valid = 0;
    wait_last("t5b");
    check_out("t5b_p0", 0, 7, 7, 0, 1);

    // Reset with both stages full
    apply_cfg(0, 0, 0, 20, 30);
    send_point(0, 0, 0);
    in_valid = 0;
    step(); step(); step();
    check_val("t6_count_pre", point_count, 1);
    out_ready = 1'b0;
    send_point(1, 0, 0);
    send_point(2, 0, 0);
    in_valid = 0;
    step();
    check_val("t6_full_valid", out_valid, 1);
    check_val("t6_full_in_ready", in_ready, 0);
    rst = 1'b1;
    #1;
    check_val("t6_rst_out_valid", out_valid, 0);
    check_val("t6_rst_cfg_ready", cfg_ready, 1);
    check_val("t6_rst_count", point_count, 0);
    step();
    rst = 1'b0;
    step();
    check_val("t6_post_cfg_ready", cfg_ready, 1);
    check_val("t6_post_count", point_count, 0);
    check_val("t6_post_out_valid", out_valid, 0);
    check_val("t6_post_in_ready", in_ready, 0);
    out_ready = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
